// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter onto one slave port, zero-wait writes, RD_LAT-cycle reads.
// Define MEM_ARBITER_FIXED_PRIO_EN for fixed m0 priority instead of round-robin.
module mem_arbiter #(
  parameter int ADDR_W = 30,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_we,
  input  logic              m0_re,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_we,
  input  logic              m1_re,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,
  output logic [ADDR_W-1:0] s_addr,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_we,
  output logic              s_re,
  input  logic [31:0]       s_rdata
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RWAIT = 1'b1;
  logic [0:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       win_q, win_d;
  logic       pend0, pend1, gnt1, any, wr, done;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
  always_comb gnt1 = pend1 & ~pend0;
`else
  logic last_q, last_d;
  always_comb begin
    gnt1   = pend1 & (~pend0 | ~last_q);
    last_d = any ? gnt1 : last_q;
  end
  // last_q resets to 1 so m0 wins the first tie
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_q <= 1'b1;
    else last_q <= last_d;
`endif
  always_comb begin
    pend0    = m0_re | (|m0_we);
    pend1    = m1_re | (|m1_we);
    any      = reset & (state_q == IDLE) & (pend0 | pend1);
    s_addr   = gnt1 ? m1_addr : m0_addr;
    s_wdata  = gnt1 ? m1_wdata : m0_wdata;
    s_we     = any ? (gnt1 ? m1_we : m0_we) : 4'h0;
    wr       = |s_we;
    s_re     = any & ~wr;
    done     = reset & (state_q == RWAIT) & (cnt_q == 3'd1);
    // a requester that dropped its read still lets the FSM finish, but gets no ready
    m0_ready = (any & wr & ~gnt1) | (done & ~win_q & pend0);
    m1_ready = (any & wr & gnt1) | (done & win_q & pend1);
    m0_rdata = s_rdata;
    m1_rdata = s_rdata;
    state_d  = s_re ? RWAIT : (done ? IDLE : state_q);
    cnt_d    = s_re ? 3'(RD_LAT) : ((state_q == RWAIT) ? cnt_q - 3'd1 : cnt_q);
    win_d    = s_re ? gnt1 : win_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench over three arbiters (RD_LAT 1, 2, 3), each with its own RAM model.
module tb_mem_arbiter;
  localparam int N = 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [29:0] m0_addr [N], m1_addr [N], s_addr [N];
  logic [31:0] m0_wdata [N], m1_wdata [N], m0_rdata [N], m1_rdata [N], s_wdata [N], s_rdata [N];
  logic [3:0]  m0_we [N], m1_we [N], s_we [N];
  logic        m0_re [N], m1_re [N], m0_ready [N], m1_ready [N], s_re [N];
  typedef struct {
    int          dut;
    logic        id;
    logic        chk;
    logic [31:0] data;
  } exp_t;
  exp_t sbq [$];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  for (genvar k = 0; k < N; k++) begin : g_s
    logic [31:0] mem [256];
    logic [7:0]  raddr;
    mem_arbiter #(.ADDR_W(30), .RD_LAT(k + 1)) u_dut (
      .clk(clk), .reset(reset),
      .m0_addr(m0_addr[k]), .m0_wdata(m0_wdata[k]), .m0_we(m0_we[k]), .m0_re(m0_re[k]),
      .m0_ready(m0_ready[k]), .m0_rdata(m0_rdata[k]),
      .m1_addr(m1_addr[k]), .m1_wdata(m1_wdata[k]), .m1_we(m1_we[k]), .m1_re(m1_re[k]),
      .m1_ready(m1_ready[k]), .m1_rdata(m1_rdata[k]),
      .s_addr(s_addr[k]), .s_wdata(s_wdata[k]), .s_we(s_we[k]), .s_re(s_re[k]),
      .s_rdata(s_rdata[k])
    );
    always @(posedge clk) begin
      if (!reset) begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
        raddr <= 8'h00;
      end else begin
        for (int b = 0; b < 4; b++)
          if (s_we[k][b]) mem[s_addr[k][7:0]][8*b +: 8] <= s_wdata[k][8*b +: 8];
        if (s_re[k]) raddr <= s_addr[k][7:0];
      end
    end
    assign s_rdata[k] = mem[raddr];
  end
  always @(negedge clk) begin
    logic        r;
    logic [31:0] rd;
    exp_t        e;
    if (reset)
      for (int k = 0; k < N; k++) begin
        if (m0_ready[k] && m1_ready[k]) begin
          tests++;
          fails++;
          $display("FAIL both_ready dut%0d: got both ready high, required at most one", k);
        end
        for (int j = 0; j < 2; j++) begin
          r  = (j == 1) ? m1_ready[k] : m0_ready[k];
          rd = (j == 1) ? m1_rdata[k] : m0_rdata[k];
          if (r) begin
            tests++;
            if (sbq.size() == 0) begin
              fails++;
              $display("FAIL sb_unexpected dut%0d m%0d: got ready, required none", k, j);
            end else begin
              e = sbq.pop_front();
              if (e.dut != k || e.id != 1'(j) || (e.chk && rd !== e.data)) begin
                fails++;
                $display("FAIL sb_ready: got dut%0d m%0d rdata %h, required dut%0d m%0d rdata %h",
                         k, j, rd, e.dut, e.id, e.data);
              end
            end
          end
        end
      end
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", n, act, exp);
    end
  endtask
  task automatic push(input int d, input logic id, input logic c, input logic [31:0] data);
    exp_t e;
    e.dut  = d;
    e.id   = id;
    e.chk  = c;
    e.data = data;
    sbq.push_back(e);
  endtask
  task automatic clr(input int d);
    m0_addr[d] = '0; m0_wdata[d] = '0; m0_we[d] = '0; m0_re[d] = 1'b0;
    m1_addr[d] = '0; m1_wdata[d] = '0; m1_we[d] = '0; m1_re[d] = 1'b0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int d = 0; d < N; d++) clr(d);
    m0_we[0] = 4'hF;
    m0_re[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_we", 32'(s_we[0]), 32'h0);
    chk("rst_s_re", 32'(s_re[0]), 32'h0);
    chk("rst_m0_ready", 32'(m0_ready[0]), 32'h0);
    clr(0);
    reset = 1'b1;
    m0_addr[0] = 30'h10; m0_wdata[0] = 32'hDEADBEEF; m0_we[0] = 4'hF;
    #1;
    chk("wr_s_we", 32'(s_we[0]), 32'hF);
    chk("wr_s_addr", 32'(s_addr[0]), 32'h10);
    chk("wr_m0_ready", 32'(m0_ready[0]), 32'h1);
    push(0, 1'b0, 1'b0, 32'h0);
    step();
    clr(0);
    chk("wr_mem", g_s[0].mem[8'h10], 32'hDEADBEEF);
    m1_addr[0] = 30'h10; m1_re[0] = 1'b1;
    #1;
    chk("rd1_s_re", 32'(s_re[0]), 32'h1);
    chk("rd1_early_ready", 32'(m1_ready[0]), 32'h0);
    push(0, 1'b1, 1'b1, 32'hDEADBEEF);
    step();
    chk("rd1_s_re_pulse", 32'(s_re[0]), 32'h0);
    chk("rd1_m1_ready", 32'(m1_ready[0]), 32'h1);
    chk("rd1_m0_quiet", 32'(m0_ready[0]), 32'h0);
    step();
    clr(0);
    m0_addr[0] = 30'h20; m0_wdata[0] = 32'h000000AA; m0_we[0] = 4'h1; m0_re[0] = 1'b1;
    #1;
    chk("wrre_s_re", 32'(s_re[0]), 32'h0);
    chk("wrre_s_we", 32'(s_we[0]), 32'h1);
    chk("wrre_m0_ready", 32'(m0_ready[0]), 32'h1);
    push(0, 1'b0, 1'b0, 32'h0);
    step();
    clr(0);
    chk("wrre_mem", g_s[0].mem[8'h20], 32'hC0DE00AA);
    reset = 1'b0;
    step();
    reset = 1'b1;
    m0_addr[0] = 30'h1; m0_wdata[0] = 32'h1; m0_we[0] = 4'hF;
    m1_addr[0] = 30'h2; m1_wdata[0] = 32'h2; m1_we[0] = 4'hF;
    for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
      push(0, 1'b0, 1'b0, 32'h0);
      chk("arb_m1_ready", 32'(m1_ready[0]), 32'h0);
`else
      push(0, 1'(i % 2), 1'b0, 32'h0);
      chk("arb_m1_ready", 32'(m1_ready[0]), 32'(i % 2));
`endif
      step();
    end
    clr(0);
    m0_addr[2] = 30'h30; m0_re[2] = 1'b1;
    m1_addr[2] = 30'h31; m1_wdata[2] = 32'h12345678; m1_we[2] = 4'hF;
    #1;
    chk("lat3_s_re", 32'(s_re[2]), 32'h1);
    chk("lat3_m1_held", 32'(m1_ready[2]), 32'h0);
    push(2, 1'b0, 1'b1, 32'hC0DE0030);
    for (int i = 1; i < 3; i++) begin
      step();
      chk("lat3_wait_m0", 32'(m0_ready[2]), 32'h0);
      chk("lat3_wait_m1", 32'(m1_ready[2]), 32'h0);
      chk("lat3_wait_s_we", 32'(s_we[2]), 32'h0);
    end
    step();
    chk("lat3_m0_ready", 32'(m0_ready[2]), 32'h1);
    chk("lat3_m1_still", 32'(m1_ready[2]), 32'h0);
    push(2, 1'b1, 1'b0, 32'h0);
    step();
    m0_re[2] = 1'b0;
    #1;
    chk("lat3_m1_grant", 32'(m1_ready[2]), 32'h1);
    chk("lat3_m1_s_we", 32'(s_we[2]), 32'hF);
    step();
    clr(2);
    chk("lat3_mem", g_s[2].mem[8'h31], 32'h12345678);
    m0_addr[1] = 30'h40; m0_re[1] = 1'b1;
    #1;
    chk("rstrd_s_re", 32'(s_re[1]), 32'h1);
    step();
    reset = 1'b0;
    #1;
    chk("rstrd_ready_in_rst", 32'(m0_ready[1]), 32'h0);
    chk("rstrd_s_re_in_rst", 32'(s_re[1]), 32'h0);
    step();
    clr(1);
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rstrd_no_ready", 32'(m0_ready[1] | m1_ready[1]), 32'h0);
      step();
    end
    m1_addr[1] = 30'h41; m1_re[1] = 1'b1;
    #1;
    chk("rstrd_regrant", 32'(s_re[1]), 32'h1);
    push(1, 1'b1, 1'b1, 32'hC0DE0041);
    step();
    chk("rstrd_wait", 32'(m1_ready[1]), 32'h0);
    step();
    chk("rstrd_m1_ready", 32'(m1_ready[1]), 32'h1);
    step();
    clr(1);
    repeat (3) step();
    chk("sb_empty", 32'(sbq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
